// File: rtl/hamming_pkg.sv
// Shared Hamming [7,4] definitions for the stream encoder and decoder.
// Codeword bit i holds Hamming position i+1: {d4,d3,d2,p4,d1,p2,p1}.
// Importing this package from both sides keeps the bit order in one place.
package hamming_pkg;

    typedef logic [3:0] nibble_t;
    typedef logic [6:0] codeword_t;

    // Bit index of each field inside a codeword.
    localparam int P1 = 0;
    localparam int P2 = 1;
    localparam int D1 = 2;
    localparam int P4 = 3;
    localparam int D2 = 4;
    localparam int D3 = 5;
    localparam int D4 = 6;

    // Nibble is {d4,d3,d2,d1}. Each parity bit covers the data bits whose
    // position number has that power of two set.
    function automatic codeword_t hamming_encode(input nibble_t n);
        codeword_t cw;
        cw     = '0;
        cw[D1] = n[0];
        cw[D2] = n[1];
        cw[D3] = n[2];
        cw[D4] = n[3];
        cw[P1] = n[0] ^ n[1] ^ n[3];
        cw[P2] = n[0] ^ n[2] ^ n[3];
        cw[P4] = n[1] ^ n[2] ^ n[3];
        return cw;
    endfunction

    // One-hot flip mask for a Hamming position 1..7; position 0 flips nothing.
    function automatic codeword_t inj_mask(input logic en, input logic [2:0] pos);
        codeword_t m;
        m = '0;
        if (en && (pos != 3'd0)) begin
            m[pos - 3'd1] = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/hamming_stream_encoder.sv
// Streaming Hamming [7,4] encoder.
// Takes bytes on a valid/ready input and emits two registered 7-bit
// codewords per byte (one per nibble) on a valid/ready output, with
// optional single-bit error injection applied as each codeword is loaded.
//
// Ports:
//   clk       - single clock, rising edge
//   reset     - synchronous, active-high
//   in_data   - byte to encode
//   in_valid  - in_data is valid
//   in_ready  - byte accepted this cycle (from state and cw_ready only)
//   cw_data   - codeword {d4,d3,d2,p4,d1,p2,p1}
//   cw_valid  - cw_data is valid
//   cw_ready  - downstream consumes cw_data this cycle
//   cw_last   - high on the second codeword of a byte
//   inj_en    - enable error injection
//   inj_pos   - Hamming position to flip (1..7), 0 = none
//   cw_count  - wrapping count of handshaken codewords
module hamming_stream_encoder
    import hamming_pkg::*;
#(
    parameter int COUNT_W   = 16,
    parameter bit LOW_FIRST = 1'b1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [7:0]         in_data,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [6:0]         cw_data,
    output logic               cw_valid,
    input  logic               cw_ready,
    output logic               cw_last,
    input  logic               inj_en,
    input  logic [2:0]         inj_pos,
    output logic [COUNT_W-1:0] cw_count
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FIRST  = 2'd1,
        SECOND = 2'd2
    } state_e;

    state_e               state_q,    state_d;
    logic [7:0]           byte_q,     byte_d;
    codeword_t            cw_data_q,  cw_data_d;
    logic                 cw_valid_q, cw_valid_d;
    logic                 cw_last_q,  cw_last_d;
    logic [COUNT_W-1:0]   count_q,    count_d;

    codeword_t            mask;
    logic                 cw_fire;

    function automatic nibble_t first_nibble(input logic [7:0] b);
        return LOW_FIRST ? b[3:0] : b[7:4];
    endfunction

    function automatic nibble_t second_nibble(input logic [7:0] b);
        return LOW_FIRST ? b[7:4] : b[3:0];
    endfunction

    // Mask is only used on load cycles, so changes to the injection inputs
    // while a codeword is stalled cannot disturb the presented value.
    assign mask     = inj_mask(inj_en, inj_pos);
    assign cw_fire  = cw_valid_q && cw_ready;
    assign in_ready = (state_q == IDLE) || ((state_q == SECOND) && cw_ready);

    always_comb begin
        state_d    = state_q;
        byte_d     = byte_q;
        cw_data_d  = cw_data_q;
        cw_valid_d = cw_valid_q;
        cw_last_d  = cw_last_q;
        count_d    = cw_fire ? count_q + {{(COUNT_W-1){1'b0}}, 1'b1} : count_q;

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    byte_d     = in_data;
                    cw_data_d  = hamming_encode(first_nibble(in_data)) ^ mask;
                    cw_valid_d = 1'b1;
                    cw_last_d  = 1'b0;
                    state_d    = FIRST;
                end
            end
            FIRST: begin
                if (cw_ready) begin
                    cw_data_d = hamming_encode(second_nibble(byte_q)) ^ mask;
                    cw_last_d = 1'b1;
                    state_d   = SECOND;
                end
            end
            SECOND: begin
                if (cw_ready) begin
                    if (in_valid) begin
                        // Back-to-back byte: reuse this handshake cycle.
                        byte_d     = in_data;
                        cw_data_d  = hamming_encode(first_nibble(in_data)) ^ mask;
                        cw_valid_d = 1'b1;
                        cw_last_d  = 1'b0;
                        state_d    = FIRST;
                    end else begin
                        cw_valid_d = 1'b0;
                        cw_last_d  = 1'b0;
                        state_d    = IDLE;
                    end
                end
            end
            default: begin
                cw_valid_d = 1'b0;
                cw_last_d  = 1'b0;
                state_d    = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            byte_q     <= 8'h00;
            cw_data_q  <= '0;
            cw_valid_q <= 1'b0;
            cw_last_q  <= 1'b0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            byte_q     <= byte_d;
            cw_data_q  <= cw_data_d;
            cw_valid_q <= cw_valid_d;
            cw_last_q  <= cw_last_d;
            count_q    <= count_d;
        end
    end

    assign cw_data  = cw_data_q;
    assign cw_valid = cw_valid_q;
    assign cw_last  = cw_last_q;
    assign cw_count = count_q;

endmodule

// File: tb/tb_hamming_stream_encoder.sv
// Directed bench for hamming_stream_encoder. Three instances share the
// stimulus: default parameters, a 4-bit counter, and high-nibble-first order.
module tb_hamming_stream_encoder;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        cw_ready;
    logic        inj_en;
    logic [2:0]  inj_pos;

    logic        in_ready_a, cw_valid_a, cw_last_a;
    logic [6:0]  cw_data_a;
    logic [15:0] cw_count_a;

    logic        in_ready_b, cw_valid_b, cw_last_b;
    logic [6:0]  cw_data_b;
    logic [3:0]  cw_count_b;

    logic        in_ready_c, cw_valid_c, cw_last_c;
    logic [6:0]  cw_data_c;
    logic [15:0] cw_count_c;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hamming_stream_encoder #(.COUNT_W(16), .LOW_FIRST(1'b1)) u_a (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready_a), .cw_data(cw_data_a), .cw_valid(cw_valid_a),
        .cw_ready(cw_ready), .cw_last(cw_last_a), .inj_en(inj_en),
        .inj_pos(inj_pos), .cw_count(cw_count_a)
    );

    hamming_stream_encoder #(.COUNT_W(4), .LOW_FIRST(1'b1)) u_b (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready_b), .cw_data(cw_data_b), .cw_valid(cw_valid_b),
        .cw_ready(cw_ready), .cw_last(cw_last_b), .inj_en(inj_en),
        .inj_pos(inj_pos), .cw_count(cw_count_b)
    );

    hamming_stream_encoder #(.COUNT_W(16), .LOW_FIRST(1'b0)) u_c (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready_c), .cw_data(cw_data_c), .cw_valid(cw_valid_c),
        .cw_ready(cw_ready), .cw_last(cw_last_c), .inj_en(inj_en),
        .inj_pos(inj_pos), .cw_count(cw_count_c)
    );

    // Receive-side syndrome, written out independently of the encoder.
    function automatic logic [2:0] syndrome(input logic [6:0] c);
        logic s1, s2, s4;
        s1 = c[0] ^ c[2] ^ c[4] ^ c[6];
        s2 = c[1] ^ c[2] ^ c[5] ^ c[6];
        s4 = c[3] ^ c[4] ^ c[5] ^ c[6];
        return {s4, s2, s1};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic chk_cw(input string tag, input logic [6:0] d, input logic v, input logic l);
        chk({tag, "_data"},  {25'd0, cw_data_a}, {25'd0, d});
        chk({tag, "_valid"}, {31'd0, cw_valid_a}, {31'd0, v});
        chk({tag, "_last"},  {31'd0, cw_last_a},  {31'd0, l});
    endtask

    initial begin
        int accepted;
        int cycles;

        reset    = 1'b1;
        in_data  = 8'h00;
        in_valid = 1'b0;
        cw_ready = 1'b0;
        inj_en   = 1'b0;
        inj_pos  = 3'd0;
        step();
        step();
        reset = 1'b0;
        settle();
        chk_cw("rst", 7'b0000000, 1'b0, 1'b0);
        chk("rst_count", {16'd0, cw_count_a}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready_a}, 32'd1);

        // Single byte B1, low nibble first.
        in_data  = 8'hB1;
        in_valid = 1'b1;
        cw_ready = 1'b1;
        step();
        in_valid = 1'b0;
        settle();
        chk_cw("b1_first", 7'b0000111, 1'b1, 1'b0);
        chk("b1_first_in_ready", {31'd0, in_ready_a}, 32'd0);
        chk("b1_hifirst_first", {25'd0, cw_data_c}, {25'd0, 7'b1010101});
        step();
        chk_cw("b1_second", 7'b1010101, 1'b1, 1'b1);
        chk("b1_second_in_ready", {31'd0, in_ready_a}, 32'd1);
        chk("b1_count1", {16'd0, cw_count_a}, 32'd1);
        chk("b1_hifirst_second", {25'd0, cw_data_c}, {25'd0, 7'b0000111});
        step();
        chk("b1_idle_valid", {31'd0, cw_valid_a}, 32'd0);
        chk("b1_count2", {16'd0, cw_count_a}, 32'd2);

        // 00 then FF back-to-back; in_data changes during FIRST must be ignored.
        in_data  = 8'h00;
        in_valid = 1'b1;
        step();
        chk_cw("bb_c0", 7'b0000000, 1'b1, 1'b0);
        in_data = 8'hFF;
        settle();
        chk("bb_c0_in_ready", {31'd0, in_ready_a}, 32'd0);
        step();
        chk_cw("bb_c1", 7'b0000000, 1'b1, 1'b1);
        chk("bb_c1_in_ready", {31'd0, in_ready_a}, 32'd1);
        step();
        in_valid = 1'b0;
        settle();
        chk_cw("bb_c2", 7'b1111111, 1'b1, 1'b0);
        chk("bb_c2_in_ready", {31'd0, in_ready_a}, 32'd0);
        step();
        chk_cw("bb_c3", 7'b1111111, 1'b1, 1'b1);
        step();
        chk("bb_idle_valid", {31'd0, cw_valid_a}, 32'd0);
        chk("bb_count", {16'd0, cw_count_a}, 32'd6);

        // Byte 04 stalled five cycles; injection inputs wiggle during the stall.
        in_data  = 8'h04;
        in_valid = 1'b1;
        cw_ready = 1'b0;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            inj_en  = i[0];
            inj_pos = 3'(i + 3);
            settle();
            chk_cw("stall", 7'b0101010, 1'b1, 1'b0);
            chk("stall_in_ready", {31'd0, in_ready_a}, 32'd0);
            chk("stall_count", {16'd0, cw_count_a}, 32'd6);
            step();
        end
        inj_en   = 1'b0;
        inj_pos  = 3'd0;
        cw_ready = 1'b1;
        step();
        chk_cw("stall_second", 7'b0000000, 1'b1, 1'b1);
        chk("stall_count7", {16'd0, cw_count_a}, 32'd7);
        step();
        chk("stall_count8", {16'd0, cw_count_a}, 32'd8);

        // Injection at position 3 on BB, then position 0 on BB.
        inj_en   = 1'b1;
        inj_pos  = 3'd3;
        in_data  = 8'hBB;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        settle();
        chk_cw("inj3_first", 7'b1010001, 1'b1, 1'b0);
        chk("inj3_syndrome", {29'd0, syndrome(cw_data_a)}, 32'd3);
        step();
        chk_cw("inj3_second", 7'b1010001, 1'b1, 1'b1);
        step();
        inj_pos  = 3'd0;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        settle();
        chk_cw("inj0_first", 7'b1010101, 1'b1, 1'b0);
        chk("inj0_syndrome", {29'd0, syndrome(cw_data_a)}, 32'd0);
        step();
        chk_cw("inj0_second", 7'b1010101, 1'b1, 1'b1);
        step();
        inj_en = 1'b0;
        chk("inj_count", {16'd0, cw_count_a}, 32'd12);

        // Reset while FIRST holds byte 4B: high nibble must never appear.
        in_data  = 8'h4B;
        in_valid = 1'b1;
        cw_ready = 1'b0;
        step();
        in_valid = 1'b0;
        chk_cw("rstmid_first", 7'b1010101, 1'b1, 1'b0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk_cw("rstmid_after", 7'b0000000, 1'b0, 1'b0);
        chk("rstmid_count", {16'd0, cw_count_a}, 32'd0);
        chk("rstmid_in_ready", {31'd0, in_ready_a}, 32'd1);
        cw_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rstmid_no_emit", {31'd0, cw_valid_a}, 32'd0);
        end

        // Nine bytes streamed: 18 handshakes, 4-bit counter wraps to 2.
        accepted = 0;
        cycles   = 0;
        in_valid = 1'b1;
        while (accepted < 9 && cycles < 60) begin
            in_data = 8'(accepted * 37 + 5);
            settle();
            if (in_ready_a) accepted++;
            step();
            cycles++;
            if (accepted == 9) in_valid = 1'b0;
        end
        in_valid = 1'b0;
        while (cw_valid_a && cycles < 60) begin
            step();
            cycles++;
        end
        chk("stream_timeout", {31'd0, (cycles >= 60)}, 32'd0);
        chk("stream_count16", {16'd0, cw_count_a}, 32'd18);
        chk("stream_count4", {28'd0, cw_count_b}, 32'd2);
        chk("stream_hifirst_count", {16'd0, cw_count_c}, 32'd18);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hamming_stream_encoder.md
Name: hamming_stream_encoder

Overview:
- Streaming Hamming [7,4] encoder. It is the transmit-side counterpart to the team's hamming_decoder.
- Accepts bytes on a valid/ready input, splits each byte into two nibbles and emits one registered 7-bit codeword per nibble on a valid/ready output.
- Optional single-bit error injection, so decoder benches and loopback links can be exercised with known correctable errors.

Parameters:
- COUNT_W, 16, width of the wrapping handshaken-codeword counter.
- LOW_FIRST, 1, 1 = low nibble (in_data[3:0]) is encoded first; 0 = high nibble first.

Ports:
- clk  input  1  single clock, all logic on rising edge
- reset  input  1  synchronous, active-high reset
- in_data  input  8  byte to encode
- in_valid  input  1  in_data is valid
- in_ready  output  1  encoder accepts in_data this cycle
- cw_data  output  7  codeword, bit i = Hamming position i+1: {d4,d3,d2,p4,d1,p2,p1}
- cw_valid  output  1  cw_data is valid
- cw_ready  input  1  downstream consumes cw_data this cycle
- cw_last  output  1  high on the second codeword of a byte
- inj_en  input  1  enable error injection
- inj_pos  input  3  Hamming position to flip (1..7); 0 means no flip
- cw_count  output  COUNT_W  number of codewords handshaken, wraps modulo 2^COUNT_W

Behaviour:
- Encoding, with nibble n = {d4,d3,d2,d1}:
  - p1 = d1^d2^d4
  - p2 = d1^d3^d4
  - p4 = d2^d3^d4
- Injection:
  - Mask = (inj_en && inj_pos!=0) ? (1 << (inj_pos-1)) : 0.
  - Sampled when each codeword is loaded into the output register, not at the byte handshake.
  - The mask is XORed into cw_data.
- Reset values:
  - state = IDLE
  - cw_valid = 0, cw_last = 0
  - cw_data = 7'b0000000
  - cw_count = 0
  - internal byte register = 0
  - Reset mid-transfer drops any held byte and pending codeword; there is no partial output afterwards.
- FSM states: IDLE (nothing held), FIRST (first codeword presented), SECOND (second codeword presented).
- in_ready = (state==IDLE) || (state==SECOND && cw_ready). It is combinational from state and cw_ready and does not depend on in_valid.
- IDLE:
  - On in_valid: latch byte; load cw_data = enc(first nibble)^mask; cw_valid=1; cw_last=0; go to FIRST.
  - Otherwise stay in IDLE.
- FIRST:
  - On cw_ready: load enc(second nibble)^mask; cw_last=1; go to SECOND.
  - If cw_ready is low, hold cw_data and cw_last stable.
- SECOND:
  - On cw_ready && in_valid: accept the new byte in the same cycle; load its first codeword; cw_last=0; go to FIRST. This makes back-to-back bytes bubble-free.
  - On cw_ready && !in_valid: cw_valid=0; cw_last=0; go to IDLE.
  - If cw_ready is low, hold.
- Latency and throughput:
  - Byte handshake at cycle t gives its first codeword valid at t+1.
  - Second codeword follows at the first cycle after the first handshake.
  - Sustained rate: 1 byte per 2 cycles with cw_ready held high.
- Output stability: cw_data, cw_valid and cw_last never change while cw_valid && !cw_ready, even if inj_en or inj_pos change.
- cw_count:
  - Increments by 1 on every cw_valid && cw_ready cycle.
  - Wraps from 2^COUNT_W-1 to 0 with no flag.
- Simultaneous events:
  - A byte is accepted and a codeword is consumed in the same cycle only in SECOND. The count increments and the new byte loads in that cycle.
  - in_valid arriving while in FIRST is ignored; in_ready is low there.
- cw_data keeps its last value when cw_valid=0; downstream logic must not sample it then.

Decomposition:
- Package hamming_pkg contains:
  - typedef logic [3:0] nibble_t, typedef logic [6:0] codeword_t.
  - Position constants P1=0, P2=1, D1=2, P4=3, D2=4, D3=5, D4=6.
  - function hamming_encode(nibble_t) -> codeword_t.
  - function inj_mask(logic en, logic [2:0] pos) -> codeword_t.
- hamming_decoder is to import the same package, so the bit order is shared.
- No sub-module. The encode function is the only combinational core and the FSM and registers stay in one module.

Test Plan:
- Reset then single byte 8'hB1 (LOW_FIRST=1), cw_ready=1, inj_en=0 -> codewords 7'b0000111 (nibble 1, cw_last=0), then 7'b1010101 (nibble B, cw_last=1); cw_count=2; cw_valid=0 afterwards.
- Bytes 8'h00 and 8'hFF back-to-back, in_valid and cw_ready held high -> 7'b0000000, 7'b0000000, 7'b1111111, 7'b1111111 on 4 consecutive cycles; in_ready high only on SECOND cycles.
- Byte 8'h04 with cw_ready low for 5 cycles -> cw_data=7'b0101010 held stable with cw_valid=1, in_ready=0 throughout; consumption resumes when cw_ready rises.
- inj_en=1, inj_pos=3, byte 8'hBB -> both codewords 7'b1010001 (bit 2 flipped); inj_pos=0 -> 7'b1010101 unmodified; the bench's hamming_decoder reports syndrome 3 in the first case.
- Assert reset while in FIRST with byte 8'h4B held -> next cycle cw_valid=0, cw_count=0, state IDLE; the high nibble is never emitted.
- COUNT_W=4, stream 9 bytes -> cw_count wraps and reads 2 after 18 handshakes.
